reward_scan: RTL and testbench

Parametrised reward engine for the EER-RL node datapath. On a start pulse it scans the first `neighborCount` entries of the neighbor table, computes a saturating per-neighbor reward, and selects the best next hop. It then updates the node's Q-value and presents a complete reward-packet field set to the packet builder. It generalises the single-entry reward block to configurable word width, table depth, energy/hop weighting and an eligibility floor.

---
 rtl/reward_scan.sv | 176 +++++++++++++++++
 tb/tb_reward_scan.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reward_scan.sv
// Neighbor-table reward scan: walks the first N entries, picks the highest-reward
// eligible next hop, derives the new Q-value and presents the reward-packet fields.
module reward_scan #(
    parameter int                    WORD_WIDTH = 16,
    parameter int                    NT_DEPTH   = 32,
    parameter int                    IDX_W      = $clog2(NT_DEPTH),
    parameter int                    E_SHIFT    = 4,
    parameter int                    H_SHIFT    = 2,
    parameter int                    HOP_COST   = 1,
    parameter logic [WORD_WIDTH-1:0] E_MIN      = 16'h0100,
    parameter logic [2:0]            PKT_REWARD = 3'd4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [IDX_W:0]        neighborCount,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    output logic [IDX_W-1:0]      nTableIndex_reward,
    output logic                  nTableRead,
    input  logic [WORD_WIDTH-1:0] mNodeID,
    input  logic [WORD_WIDTH-1:0] mNodeHops,
    input  logic [WORD_WIDTH-1:0] mNodeQValue,
    input  logic [WORD_WIDTH-1:0] mNodeEnergy,
    output logic                  busy,
    output logic                  reward_done,
    output logic                  noCandidate,
    output logic [WORD_WIDTH-1:0] chosenHop,
    output logic [WORD_WIDTH-1:0] rQValue,
    output logic [WORD_WIDTH-1:0] rSourceID,
    output logic [WORD_WIDTH-1:0] rEnergyLeft,
    output logic [WORD_WIDTH-1:0] rSourceHops,
    output logic [WORD_WIDTH-1:0] rDestinationID,
    output logic [2:0]            rPacketType
);

    localparam int AW = WORD_WIDTH + 2;
    localparam int PW = WORD_WIDTH + H_SHIFT + 2;
    localparam logic [AW-1:0]         SUM_MAX = {2'b00, {WORD_WIDTH{1'b1}}};
    localparam logic [PW-1:0]         PEN_MAX = {{(H_SHIFT + 2){1'b0}}, {WORD_WIDTH{1'b1}}};
    localparam logic [IDX_W:0]        CNT_MAX = (IDX_W + 1)'(NT_DEPTH);
    localparam logic [IDX_W:0]        CNT_ONE = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0]      IDX_ONE = IDX_W'(1);
    localparam logic [WORD_WIDTH-1:0] COST    = WORD_WIDTH'(HOP_COST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        PACK  = 2'd3
    } state_t;

    state_t                state;
    logic [IDX_W:0]        n_cnt;
    logic                  rd_vld;
    logic [WORD_WIDTH-1:0] id_cap;
    logic [WORD_WIDTH-1:0] hops_cap;
    logic [WORD_WIDTH-1:0] energy_cap;
    logic                  have_best;
    logic [WORD_WIDTH-1:0] best_r;
    logic [WORD_WIDTH-1:0] best_id;

    logic [AW-1:0]         sum_raw;
    logic [PW-1:0]         pen_raw;
    logic [WORD_WIDTH-1:0] sum_sat;
    logic [WORD_WIDTH-1:0] pen_sat;
    logic [WORD_WIDTH-1:0] r_cur;
    logic [WORD_WIDTH-1:0] q_new;
    logic                  elig;
    logic                  take;
    logic                  last_idx;
    logic [IDX_W:0]        cnt_clamp;

    // Reward of the entry currently on the read-data bus, saturated at both ends.
    always_comb begin
        sum_raw   = {2'b00, mNodeQValue} + ({2'b00, mNodeEnergy} >> E_SHIFT);
        sum_sat   = (sum_raw > SUM_MAX) ? '1 : sum_raw[WORD_WIDTH-1:0];
        pen_raw   = {{(H_SHIFT + 2){1'b0}}, mNodeHops} << H_SHIFT;
        pen_sat   = (pen_raw > PEN_MAX) ? '1 : pen_raw[WORD_WIDTH-1:0];
        r_cur     = (sum_sat > pen_sat) ? (sum_sat - pen_sat) : '0;
        elig      = (mNodeHops != '1) && (mNodeHops < hops_cap) && (mNodeEnergy >= E_MIN);
        take      = rd_vld && elig && (!have_best || (r_cur > best_r));
        q_new     = (best_r >= COST) ? (best_r - COST) : '0;
        last_idx  = ({1'b0, nTableIndex_reward} == (n_cnt - CNT_ONE));
        cnt_clamp = (neighborCount > CNT_MAX) ? CNT_MAX : neighborCount;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            n_cnt              <= '0;
            rd_vld             <= 1'b0;
            id_cap             <= '0;
            hops_cap           <= '0;
            energy_cap         <= '0;
            have_best          <= 1'b0;
            best_r             <= '0;
            best_id            <= '0;
            nTableIndex_reward <= '0;
            nTableRead         <= 1'b0;
            busy               <= 1'b0;
            reward_done        <= 1'b0;
            noCandidate        <= 1'b0;
            chosenHop          <= '0;
            rQValue            <= '0;
            rSourceID          <= '0;
            rEnergyLeft        <= '0;
            rSourceHops        <= '0;
            rDestinationID     <= '0;
            rPacketType        <= '0;
        end else begin
            reward_done <= 1'b0;
            // Read data lags the address by one cycle; rd_vld tracks that.
            rd_vld      <= nTableRead;

            if (take) begin
                have_best <= 1'b1;
                best_r    <= r_cur;
                best_id   <= mNodeID;
            end

            case (state)
                IDLE: begin
                    // The reward_done cycle is still IDLE but must not accept.
                    if (en && !reward_done) begin
                        id_cap             <= myNodeID;
                        hops_cap           <= hopsFromSink;
                        energy_cap         <= myEnergy;
                        n_cnt              <= cnt_clamp;
                        have_best          <= 1'b0;
                        best_r             <= '0;
                        best_id            <= '0;
                        busy               <= 1'b1;
                        nTableIndex_reward <= '0;
                        if (cnt_clamp == '0) begin
                            state <= DRAIN;
                        end else begin
                            state      <= SCAN;
                            nTableRead <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (last_idx) begin
                        nTableRead         <= 1'b0;
                        nTableIndex_reward <= '0;
                        state              <= DRAIN;
                    end else begin
                        nTableIndex_reward <= nTableIndex_reward + IDX_ONE;
                    end
                end
                DRAIN: begin
                    state <= PACK;
                end
                PACK: begin
                    noCandidate    <= !have_best;
                    chosenHop      <= have_best ? best_id : '0;
                    rDestinationID <= have_best ? best_id : '0;
                    rQValue        <= have_best ? q_new : '0;
                    rSourceID      <= id_cap;
                    rEnergyLeft    <= energy_cap;
                    rSourceHops    <= hops_cap;
                    rPacketType    <= PKT_REWARD;
                    reward_done    <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reward_scan.sv
// Bench for reward_scan: behavioural neighbor-table model plus directed and
// randomized scans scored against a plain-arithmetic reward reference.
module tb_reward_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic [5:0]  neighborCount;
    logic [15:0] myNodeID;
    logic [15:0] hopsFromSink;
    logic [15:0] myEnergy;
    logic [4:0]  nTableIndex_reward;
    logic        nTableRead;
    logic [15:0] mNodeID;
    logic [15:0] mNodeHops;
    logic [15:0] mNodeQValue;
    logic [15:0] mNodeEnergy;
    logic        busy;
    logic        reward_done;
    logic        noCandidate;
    logic [15:0] chosenHop;
    logic [15:0] rQValue;
    logic [15:0] rSourceID;
    logic [15:0] rEnergyLeft;
    logic [15:0] rSourceHops;
    logic [15:0] rDestinationID;
    logic [2:0]  rPacketType;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tab_id   [32];
    logic [15:0] tab_hops [32];
    logic [15:0] tab_q    [32];
    logic [15:0] tab_e    [32];

    reward_scan dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .neighborCount      (neighborCount),
        .myNodeID           (myNodeID),
        .hopsFromSink       (hopsFromSink),
        .myEnergy           (myEnergy),
        .nTableIndex_reward (nTableIndex_reward),
        .nTableRead         (nTableRead),
        .mNodeID            (mNodeID),
        .mNodeHops          (mNodeHops),
        .mNodeQValue        (mNodeQValue),
        .mNodeEnergy        (mNodeEnergy),
        .busy               (busy),
        .reward_done        (reward_done),
        .noCandidate        (noCandidate),
        .chosenHop          (chosenHop),
        .rQValue            (rQValue),
        .rSourceID          (rSourceID),
        .rEnergyLeft        (rEnergyLeft),
        .rSourceHops        (rSourceHops),
        .rDestinationID     (rDestinationID),
        .rPacketType        (rPacketType)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // neighbor table: registered read, data one cycle after the address
    always @(posedge clk) begin
        if (nTableRead) begin
            mNodeID     <= tab_id[nTableIndex_reward];
            mNodeHops   <= tab_hops[nTableIndex_reward];
            mNodeQValue <= tab_q[nTableIndex_reward];
            mNodeEnergy <= tab_e[nTableIndex_reward];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(reward_done), 0);
        check({tag, "_read"}, 32'(nTableRead), 0);
        check({tag, "_index"}, 32'(nTableIndex_reward), 0);
        check({tag, "_nocand"}, 32'(noCandidate), 0);
        check({tag, "_chosen"}, 32'(chosenHop), 0);
        check({tag, "_rq"}, 32'(rQValue), 0);
        check({tag, "_src"}, 32'(rSourceID), 0);
        check({tag, "_energy"}, 32'(rEnergyLeft), 0);
        check({tag, "_hops"}, 32'(rSourceHops), 0);
        check({tag, "_dest"}, 32'(rDestinationID), 0);
        check({tag, "_ptype"}, 32'(rPacketType), 0);
    endtask

    task automatic set_entry(input int i, input logic [15:0] id, input logic [15:0] hops,
                             input logic [15:0] q, input logic [15:0] e);
        tab_id[i]   = id;
        tab_hops[i] = hops;
        tab_q[i]    = q;
        tab_e[i]    = e;
    endtask

    task automatic fill_random(input int hsink);
        for (int i = 0; i < 32; i++) begin
            tab_id[i] = 16'($urandom_range(1, 16'hFFFF));
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                tab_hops[i] = tab_hops[i-1];
                tab_q[i]    = tab_q[i-1];
                tab_e[i]    = tab_e[i-1];
            end else begin
                tab_hops[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, hsink + 2));
                tab_q[i]    = 16'($urandom);
                tab_e[i]    = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'h00F0, 16'h0110))
                                                          : 16'($urandom);
            end
        end
    endtask

    // Reference: reward per the stated rules, evaluated with plain integers.
    function automatic void model(input int n, input int hsink,
                                  output int exp_id, output int exp_rq, output int exp_none);
        int best_i;
        int best_r;
        int sum;
        int pen;
        int r;
        best_i = -1;
        best_r = 0;
        for (int i = 0; i < n; i++) begin
            if (int'(tab_hops[i]) != 65535 && int'(tab_hops[i]) < hsink && int'(tab_e[i]) >= 256) begin
                sum = int'(tab_q[i]) + int'(tab_e[i]) / 16;
                if (sum > 65535) sum = 65535;
                pen = int'(tab_hops[i]) * 4;
                if (pen > 65535) pen = 65535;
                r = sum - pen;
                if (r < 0) r = 0;
                if (best_i < 0 || r > best_r) begin
                    best_i = i;
                    best_r = r;
                end
            end
        end
        exp_none = (best_i < 0) ? 1 : 0;
        exp_id   = (best_i < 0) ? 0 : int'(tab_id[best_i]);
        exp_rq   = (best_i < 0 || best_r < 1) ? 0 : best_r - 1;
    endfunction

    task automatic run_scan(input logic [5:0] cnt, input logic [15:0] my_id,
                            input logic [15:0] hsink, input logic [15:0] my_e, input bit poke);
        int n_eff;
        int exp_id;
        int exp_rq;
        int exp_none;
        int done_cyc;
        logic [4:0] seen[$];
        n_eff = (int'(cnt) > 32) ? 32 : int'(cnt);
        model(n_eff, int'(hsink), exp_id, exp_rq, exp_none);

        @(negedge clk);
        en            = 1'b1;
        neighborCount = cnt;
        myNodeID      = my_id;
        hopsFromSink  = hsink;
        myEnergy      = my_e;
        @(negedge clk);
        en            = 1'b0;
        myNodeID      = 16'($urandom);
        hopsFromSink  = 16'($urandom);
        myEnergy      = 16'($urandom);
        neighborCount = 6'($urandom);
        check("busy_after_accept", 32'(busy), 1);

        done_cyc = 0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            if (nTableRead) seen.push_back(nTableIndex_reward);
            if (reward_done) begin
                done_cyc = cyc;
                break;
            end
            en = (poke && cyc == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
        end

        check("done_cycle", 32'(done_cyc), 32'((n_eff == 0) ? 3 : n_eff + 3));
        check("read_count", 32'(seen.size()), 32'(n_eff));
        foreach (seen[i]) check("read_index", 32'(seen[i]), 32'(i));
        check("nocand", 32'(noCandidate), 32'(exp_none));
        check("chosen_hop", 32'(chosenHop), 32'(exp_id));
        check("dest_id", 32'(rDestinationID), 32'(exp_id));
        check("rq_value", 32'(rQValue), 32'(exp_rq));
        check("src_id", 32'(rSourceID), 32'(my_id));
        check("energy_left", 32'(rEnergyLeft), 32'(my_e));
        check("src_hops", 32'(rSourceHops), 32'(hsink));
        check("packet_type", 32'(rPacketType), 4);
        check("idle_read", 32'(nTableRead), 0);
        check("idle_index", 32'(nTableIndex_reward), 0);

        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("done_pulse_width", 32'(reward_done), 0);
        check("en_in_done_ignored", 32'(busy), 0);
        check("result_hold", 32'(chosenHop), 32'(exp_id));
    endtask

    initial begin
        bit found;
        bit saw_done;

        rst           = 1'b1;
        en            = 1'b0;
        neighborCount = '0;
        myNodeID      = '0;
        hopsFromSink  = '0;
        myEnergy      = '0;
        for (int i = 0; i < 32; i++) set_entry(i, 16'(i + 1), 16'hFFFF, '0, '0);

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_reset_busy", 32'(busy), 0);
            check("post_reset_read", 32'(nTableRead), 0);
            check("post_reset_done", 32'(reward_done), 0);
        end

        // single neighbor: R = 0x080C, new Q = 0x080B
        set_entry(0, 16'd5, 16'd1, 16'h0010, 16'h8000);
        run_scan(6'd1, 16'h0A01, 16'd2, 16'h1234, 1'b0);

        // tie between entries 1 and 2; 0 under E_MIN, 3 too far from sink
        set_entry(0, 16'd11, 16'd1, 16'h0500, 16'h00FF);
        set_entry(1, 16'd22, 16'd3, 16'h0100, 16'h1000);
        set_entry(2, 16'd33, 16'd3, 16'h0100, 16'h1000);
        set_entry(3, 16'd44, 16'd10, 16'hF000, 16'hF000);
        run_scan(6'd4, 16'h0A02, 16'd10, 16'h2222, 1'b0);

        // upper saturation: R = 0xFFFF
        set_entry(0, 16'd7, 16'd0, 16'hFFF0, 16'hFFFF);
        run_scan(6'd1, 16'h0A03, 16'd5, 16'h3333, 1'b0);

        // lower saturation: penalty exceeds sum, R = 0 but still eligible
        set_entry(0, 16'd9, 16'd5, 16'h0000, 16'h0100);
        run_scan(6'd1, 16'h0A04, 16'd8, 16'h4444, 1'b0);

        // empty scan
        run_scan(6'd0, 16'h0A05, 16'd8, 16'h5555, 1'b1);

        // nothing eligible
        set_entry(0, 16'd1, 16'hFFFF, 16'h1000, 16'h1000);
        set_entry(1, 16'd2, 16'd8, 16'h1000, 16'h1000);
        set_entry(2, 16'd3, 16'd1, 16'h1000, 16'h00FF);
        run_scan(6'd3, 16'h0A06, 16'd8, 16'h6666, 1'b0);

        // oversized count clamps to the table depth
        fill_random(12);
        run_scan(6'd63, 16'h0A07, 16'd12, 16'h7777, 1'b0);

        for (int t = 0; t < 12; t++) begin
            int hs;
            hs = $urandom_range(1, 20);
            fill_random(hs);
            run_scan(6'($urandom_range(0, 40)), 16'($urandom), 16'(hs), 16'($urandom),
                     1'($urandom_range(0, 1)));
        end

        // reset mid-scan at read index 3
        fill_random(10);
        @(negedge clk);
        en            = 1'b1;
        neighborCount = 6'd8;
        myNodeID      = 16'h0B0B;
        hopsFromSink  = 16'd10;
        myEnergy      = 16'h0C0C;
        @(negedge clk);
        en    = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (nTableRead && nTableIndex_reward == 5'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached_index3", 32'(found), 1);
        rst = 1'b1;
        #1;
        check_idle_zero("abort");
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        saw_done = 1'b0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (reward_done) saw_done = 1'b1;
        end
        check("no_done_after_abort", 32'(saw_done), 0);

        // restart after abort, with a stray en pulse mid-scan
        run_scan(6'd8, 16'h0D0D, 16'd10, 16'h0E0E, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
